// File: rtl/eeprom_arb_pkg.sv
// Shared definitions for the EEPROM access arbiter: FSM encoding and requester IDs.
package eeprom_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WR_GAP    = 3'd4,
    ST_COMPLETE  = 3'd5
  } arb_state_e;

  localparam logic REQ_ID_R0 = 1'b0;
  localparam logic REQ_ID_R1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win last time
// is granted; rr_last resets to r1 so r0 takes the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  import eeprom_arb_pkg::*;

  logic rr_last_q;
  logic rr_last_d;

  // Grant decision and next value of the last-winner register.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rr_last_d = rr_last_q;
    if (en) begin
      if (req0 && req1) begin
        if (rr_last_q == REQ_ID_R1) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b0;
      end
      if (gnt0) begin
        rr_last_d = REQ_ID_R0;
      end else if (gnt1) begin
        rr_last_d = REQ_ID_R1;
      end else begin
        rr_last_d = rr_last_q;
      end
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // Last-winner register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= REQ_ID_R1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Shares one I2C EEPROM driver between two requesters. Sequences start/ready,
// retries NAKed transfers and holds off after writes for the EEPROM write cycle.
module eeprom_access_arbiter #(
  parameter  int ADDR_BYTE_NUM = 1,
  parameter  int DATA_BYTE_NUM = 1,
  parameter  int TWR_CYC       = 250_000,
  parameter  int MAX_RETRY     = 3,
  parameter  int BUSY_TO       = 1024,
  localparam int AW            = ADDR_BYTE_NUM * 8,
  localparam int DW            = DATA_BYTE_NUM * 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          r0_valid,
  input  logic          r0_rw,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_accept,
  output logic          r0_done,
  output logic          r0_err,
  input  logic          r1_valid,
  input  logic          r1_rw,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_accept,
  output logic          r1_done,
  output logic          r1_err,
  output logic [DW-1:0] rdata,
  output logic          iic_start,
  input  logic          iic_ready,
  output logic          iic_rw_flag,
  output logic [AW-1:0] iic_word_addr,
  output logic [DW-1:0] iic_wdata,
  input  logic [DW-1:0] iic_rdata,
  input  logic          iic_rdata_valid,
  input  logic          iic_ack_error
);
  import eeprom_arb_pkg::*;

  localparam int TW_W = (TWR_CYC > 1) ? $clog2(TWR_CYC) : 1;
  localparam int BT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d, cmd_rw_q, cmd_rw_d, fail_q, fail_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic [TW_W-1:0] twr_cnt_q, twr_cnt_d;
  logic [BT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic r0_accept_q, r0_accept_d, r1_accept_q, r1_accept_d;
  logic r0_done_q, r0_done_d, r1_done_q, r1_done_d;
  logic r0_err_q, r0_err_d, r1_err_q, r1_err_d, iic_start_q, iic_start_d;
  logic gnt0_s, gnt1_s, fail_now_s, finish_s, fin_err_s;

  rr_arb2 u_rr_arb2 (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .en   (state_q == ST_IDLE),
    .req0 (r0_valid),
    .req1 (r1_valid),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s)
  );

  assign fail_now_s = fail_q | iic_ack_error;
  assign finish_s   = (state_d == ST_COMPLETE) && (state_q != ST_COMPLETE);
  assign fin_err_s  = (state_q == ST_WAIT_BUSY) || ((state_q == ST_WAIT_DONE) && fail_now_s);

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: issue, wait for the driver, retry or finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = (gnt0_s || gnt1_s) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:     state_d = iic_ready ? ST_WAIT_BUSY : ST_ISSUE;
      ST_WAIT_BUSY: begin
        if (!iic_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (busy_cnt_q == BT_W'(BUSY_TO - 1)) begin
          state_d = ST_COMPLETE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!iic_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (fail_now_s) begin
          state_d = (retry_q < RT_W'(MAX_RETRY)) ? ST_ISSUE : ST_COMPLETE;
        end else begin
          state_d = cmd_rw_q ? ST_COMPLETE : ST_WR_GAP;
        end
      end
      ST_WR_GAP:    state_d = (twr_cnt_q == TW_W'(TWR_CYC - 1)) ? ST_COMPLETE : ST_WR_GAP;
      ST_COMPLETE:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values: capture, counters, failure flag, pulses.
  always_comb begin
    owner_d     = owner_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rbuf_d      = rbuf_q;
    rdata_d     = rdata_q;
    fail_d      = fail_q;
    retry_d     = retry_q;
    twr_cnt_d   = twr_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    r0_accept_d = 1'b0;
    r1_accept_d = 1'b0;
    r0_done_d   = 1'b0;
    r1_done_d   = 1'b0;
    r0_err_d    = 1'b0;
    r1_err_d    = 1'b0;
    iic_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt0_s) begin
          owner_d     = REQ_ID_R0;
          cmd_rw_d    = r0_rw;
          cmd_addr_d  = r0_addr;
          cmd_wdata_d = r0_wdata;
          r0_accept_d = 1'b1;
        end else if (gnt1_s) begin
          owner_d     = REQ_ID_R1;
          cmd_rw_d    = r1_rw;
          cmd_addr_d  = r1_addr;
          cmd_wdata_d = r1_wdata;
          r1_accept_d = 1'b1;
        end else begin
          owner_d = owner_q;
        end
      end
      ST_ISSUE: begin
        if (iic_ready) begin
          iic_start_d = 1'b1;
          busy_cnt_d  = {BT_W{1'b0}};
        end else begin
          iic_start_d = 1'b0;
        end
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        fail_d     = fail_now_s;
        rbuf_d     = iic_rdata_valid ? iic_rdata : rbuf_q;
        busy_cnt_d = (state_q == ST_WAIT_BUSY) ? busy_cnt_q + BT_W'(1) : busy_cnt_q;
        if ((state_q == ST_WAIT_DONE) && iic_ready) begin
          if (state_d == ST_ISSUE) begin
            retry_d = retry_q + RT_W'(1);
            fail_d  = 1'b0;
          end else if (!fail_now_s && cmd_rw_q) begin
            rdata_d = iic_rdata_valid ? iic_rdata : rbuf_q;
          end else if (!fail_now_s) begin
            twr_cnt_d = {TW_W{1'b0}};
          end else begin
            fail_d = fail_now_s;
          end
        end else begin
          retry_d = retry_q;
        end
      end
      ST_WR_GAP:   twr_cnt_d = twr_cnt_q + TW_W'(1);
      ST_COMPLETE: begin
        retry_d = {RT_W{1'b0}};
        fail_d  = 1'b0;
      end
      default: fail_d = 1'b0;
    endcase
    if (finish_s) begin
      if (owner_q == REQ_ID_R0) begin
        r0_done_d = 1'b1;
        r0_err_d  = fin_err_s;
      end else begin
        r1_done_d = 1'b1;
        r1_err_d  = fin_err_s;
      end
    end else begin
      r0_done_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      owner_q <= REQ_ID_R0;        cmd_rw_q <= 1'b0;
      cmd_addr_q <= {AW{1'b0}};    cmd_wdata_q <= {DW{1'b0}};
      rbuf_q <= {DW{1'b0}};        rdata_q <= {DW{1'b0}};
      fail_q <= 1'b0;              retry_q <= {RT_W{1'b0}};
      twr_cnt_q <= {TW_W{1'b0}};   busy_cnt_q <= {BT_W{1'b0}};
      r0_accept_q <= 1'b0;         r1_accept_q <= 1'b0;
      r0_done_q <= 1'b0;           r1_done_q <= 1'b0;
      r0_err_q <= 1'b0;            r1_err_q <= 1'b0;
      iic_start_q <= 1'b0;
    end else begin
      owner_q <= owner_d;          cmd_rw_q <= cmd_rw_d;
      cmd_addr_q <= cmd_addr_d;    cmd_wdata_q <= cmd_wdata_d;
      rbuf_q <= rbuf_d;            rdata_q <= rdata_d;
      fail_q <= fail_d;            retry_q <= retry_d;
      twr_cnt_q <= twr_cnt_d;      busy_cnt_q <= busy_cnt_d;
      r0_accept_q <= r0_accept_d;  r1_accept_q <= r1_accept_d;
      r0_done_q <= r0_done_d;      r1_done_q <= r1_done_d;
      r0_err_q <= r0_err_d;        r1_err_q <= r1_err_d;
      iic_start_q <= iic_start_d;
    end
  end

  assign r0_accept     = r0_accept_q;
  assign r1_accept     = r1_accept_q;
  assign r0_done       = r0_done_q;
  assign r1_done       = r1_done_q;
  assign r0_err        = r0_err_q;
  assign r1_err        = r1_err_q;
  assign rdata         = rdata_q;
  assign iic_start     = iic_start_q;
  assign iic_rw_flag   = cmd_rw_q;
  assign iic_word_addr = cmd_addr_q;
  assign iic_wdata     = cmd_wdata_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Directed bench for eeprom_access_arbiter with a small I2C driver / EEPROM model.
module tb_eeprom_access_arbiter;
  localparam int TWR = 20;
  localparam int MAXR = 3;
  localparam int BTO = 16;

  logic sys_clk, sys_rst;
  logic r0_valid, r0_rw, r1_valid, r1_rw;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic r0_accept, r1_accept, r0_done, r1_done, r0_err, r1_err;
  logic [7:0] rdata, iic_word_addr, iic_wdata, iic_rdata;
  logic iic_start, iic_ready, iic_rw_flag, iic_rdata_valid, iic_ack_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  eeprom_access_arbiter #(
    .ADDR_BYTE_NUM(1), .DATA_BYTE_NUM(1), .TWR_CYC(TWR), .MAX_RETRY(MAXR), .BUSY_TO(BTO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .r0_valid(r0_valid), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_accept(r0_accept), .r0_done(r0_done), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_accept(r1_accept), .r1_done(r1_done), .r1_err(r1_err),
    .rdata(rdata), .iic_start(iic_start), .iic_ready(iic_ready), .iic_rw_flag(iic_rw_flag),
    .iic_word_addr(iic_word_addr), .iic_wdata(iic_wdata), .iic_rdata(iic_rdata),
    .iic_rdata_valid(iic_rdata_valid), .iic_ack_error(iic_ack_error)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Driver / EEPROM model: ready drops after start, busy 4 cycles, NAKs the
  // first nak_cfg attempts counted from nak_base, or ignores start when hang.
  logic [7:0] mem [0:255];
  int m_busy, start_cnt = 0, start_cyc = 0, rise_cyc = 0, overlap_cnt = 0;
  int nak_cfg = 0, nak_base = 0;
  bit hang = 1'b0;
  logic m_rw, m_nak;
  logic [7:0] m_addr, m_wdata;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      iic_ready <= 1'b1; iic_ack_error <= 1'b0; iic_rdata_valid <= 1'b0;
      iic_rdata <= 8'h00; m_busy <= 0;
    end else begin
      iic_ack_error <= 1'b0;
      iic_rdata_valid <= 1'b0;
      if (iic_start) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
        m_rw <= iic_rw_flag; m_addr <= iic_word_addr; m_wdata <= iic_wdata;
        if (!iic_ready) overlap_cnt <= overlap_cnt + 1;
        if (!hang && iic_ready) begin
          iic_ready <= 1'b0;
          m_busy <= 3;
          m_nak <= ((start_cnt - nak_base) < nak_cfg);
        end
      end else if (!iic_ready) begin
        if (m_busy == 1) begin
          iic_ack_error <= m_nak;
          if (m_rw) begin
            iic_rdata_valid <= 1'b1;
            iic_rdata <= mem[m_addr];
          end else if (!m_nak) begin
            mem[m_addr] <= m_wdata;
          end
        end
        if (m_busy == 0) begin
          iic_ready <= 1'b1;
          rise_cyc <= cyc + 1;
        end else begin
          m_busy <= m_busy - 1;
        end
      end
    end
  end

  // Output monitor: pulse counts, timestamps and values captured with done.
  int r0_done_n = 0, r1_done_n = 0, a0_cyc = 0, a1_cyc = 0, d0_cyc = 0, d1_cyc = 0, dbl_acc = 0;
  logic d0_err, d1_err, r0_acc_prev = 1'b0, r1_acc_prev = 1'b0;
  logic [7:0] d0_rdata, d1_rdata;
  int grants[$];

  always @(negedge sys_clk) begin
    if (r0_accept) begin grants.push_back(0); a0_cyc = cyc; end
    if (r1_accept) begin grants.push_back(1); a1_cyc = cyc; end
    if ((r0_accept && r0_acc_prev) || (r1_accept && r1_acc_prev)) dbl_acc++;
    r0_acc_prev = r0_accept;
    r1_acc_prev = r1_accept;
    if (r0_done) begin r0_done_n++; d0_cyc = cyc; d0_err = r0_err; d0_rdata = rdata; end
    if (r1_done) begin r1_done_n++; d1_cyc = cyc; d1_err = r1_err; d1_rdata = rdata; end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for its accept, then drop valid.
  task automatic req(input int id, input logic rw, input logic [7:0] addr, input logic [7:0] wd);
    int n = 0;
    if (id == 0) begin r0_rw = rw; r0_addr = addr; r0_wdata = wd; r0_valid = 1'b1; end
    else begin r1_rw = rw; r1_addr = addr; r1_wdata = wd; r1_valid = 1'b1; end
    while (!((id == 0) ? r0_accept : r1_accept) && n < 200) begin step(); n++; end
    checks++;
    if (!((id == 0) ? r0_accept : r1_accept)) begin
      errors++; $display("FAIL accept_r%0d: no accept within %0d cycles", id, n);
    end
    if (id == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  task automatic wait_done(input int id, input int target, input int budget);
    int n = 0;
    while (((id == 0) ? r0_done_n : r1_done_n) < target && n < budget) begin step(); n++; end
    checks++;
    if (((id == 0) ? r0_done_n : r1_done_n) < target) begin
      errors++; $display("FAIL done_r%0d: no done within %0d cycles", id, budget);
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    repeat (3) step();
    obs = {r0_accept, r1_accept, r0_done, r1_done, r0_err, r1_err, iic_start, iic_rw_flag,
           iic_word_addr, iic_wdata};
    checks++;
    if (obs !== 24'h0) begin errors++; $display("FAIL reset_outputs: got %h, expected 000000", obs); end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h, expected 00", rdata); end
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    int s0 = start_cnt;
    req(0, 1'b0, 8'h05, 8'h37);
    wait_done(0, r0_done_n + 1, 300);
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL wr_starts: got %0d, expected 1", start_cnt - s0); end
    checks++;
    if ({m_rw, m_addr, m_wdata} !== {1'b0, 8'h05, 8'h37}) begin
      errors++; $display("FAIL wr_cmd: got rw=%b addr=%h data=%h, expected 0/05/37", m_rw, m_addr, m_wdata);
    end
    checks++;
    if (d0_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b, expected 0", d0_err); end
    checks++;
    if (d0_cyc - rise_cyc != TWR + 1) begin
      errors++; $display("FAIL wr_gap: got %0d cycles, expected %0d", d0_cyc - rise_cyc, TWR + 1);
    end
  endtask

  task automatic test_read();
    req(1, 1'b1, 8'h05, 8'h00);
    wait_done(1, r1_done_n + 1, 300);
    checks++;
    if (d1_rdata !== 8'h37) begin errors++; $display("FAIL rd_data: got %h, expected 37", d1_rdata); end
    checks++;
    if (d1_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b, expected 0", d1_err); end
    checks++;
    if (d1_cyc - rise_cyc != 1) begin
      errors++; $display("FAIL rd_no_gap: got %0d cycles, expected 1", d1_cyc - rise_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int g0 = grants.size();
    for (int r = 0; r < 2; r++) begin
      int n = 0;
      int t0 = r0_done_n;
      int t1 = r1_done_n;
      r0_rw = 1'b1; r0_addr = 8'h05; r0_wdata = 8'h00;
      r1_rw = 1'b0; r1_addr = 8'h20 + 8'(r); r1_wdata = 8'h5A + 8'(r);
      r0_valid = 1'b1; r1_valid = 1'b1;
      while ((r0_done_n < t0 + 1 || r1_done_n < t1 + 1) && n < 600) begin
        step(); n++;
        if (r0_accept) r0_valid = 1'b0;
        if (r1_accept) r1_valid = 1'b0;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      checks++;
      if (r0_done_n != t0 + 1 || r1_done_n != t1 + 1) begin
        errors++; $display("FAIL b2b_done_round%0d: got %0d/%0d dones, expected 1/1", r, r0_done_n - t0, r1_done_n - t1);
      end
      checks++;
      if (d0_rdata !== 8'h37) begin errors++; $display("FAIL b2b_rdata_round%0d: got %h, expected 37", r, d0_rdata); end
      checks++;
      if (a1_cyc - d0_cyc != 2) begin
        errors++; $display("FAIL b2b_accept_gap_round%0d: got %0d, expected 2", r, a1_cyc - d0_cyc);
      end
    end
    checks++;
    if (grants.size() - g0 != 4) begin
      errors++; $display("FAIL b2b_grant_count: got %0d, expected 4", grants.size() - g0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[g0 + i] != (i % 2)) begin
          errors++; $display("FAIL b2b_grant_%0d: got r%0d, expected r%0d", i, grants[g0 + i], i % 2);
        end
      end
    end
    checks++;
    if (dbl_acc != 0) begin errors++; $display("FAIL accept_width: got %0d long pulses, expected 0", dbl_acc); end
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL no_interleave: got %0d overlaps, expected 0", overlap_cnt); end
  endtask

  task automatic test_retry();
    int s0;
    nak_base = start_cnt; nak_cfg = 2; s0 = start_cnt;
    req(0, 1'b0, 8'h30, 8'hC3);
    wait_done(0, r0_done_n + 1, 600);
    checks++;
    if (start_cnt - s0 != 3) begin errors++; $display("FAIL retry2_starts: got %0d, expected 3", start_cnt - s0); end
    checks++;
    if (d0_err !== 1'b0) begin errors++; $display("FAIL retry2_err: got %b, expected 0", d0_err); end
    checks++;
    if (d0_cyc - rise_cyc != TWR + 1) begin
      errors++; $display("FAIL retry2_gap: got %0d, expected %0d", d0_cyc - rise_cyc, TWR + 1);
    end
    nak_base = start_cnt; nak_cfg = 100; s0 = start_cnt;
    req(0, 1'b0, 8'h31, 8'h3C);
    wait_done(0, r0_done_n + 1, 600);
    checks++;
    if (start_cnt - s0 != MAXR + 1) begin
      errors++; $display("FAIL nak_starts: got %0d, expected %0d", start_cnt - s0, MAXR + 1);
    end
    checks++;
    if (d0_err !== 1'b1) begin errors++; $display("FAIL nak_err: got %b, expected 1", d0_err); end
    checks++;
    if (d0_cyc - rise_cyc != 1) begin
      errors++; $display("FAIL nak_no_gap: got %0d, expected 1", d0_cyc - rise_cyc);
    end
    nak_cfg = 0;
  endtask

  task automatic test_timeout();
    int s0 = start_cnt;
    hang = 1'b1;
    req(0, 1'b0, 8'h40, 8'h11);
    r1_rw = 1'b1; r1_addr = 8'h05; r1_wdata = 8'h00; r1_valid = 1'b1;
    wait_done(0, r0_done_n + 1, 200);
    hang = 1'b0;
    checks++;
    if (d0_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b, expected 1", d0_err); end
    checks++;
    if (d0_cyc - start_cyc != BTO) begin
      errors++; $display("FAIL to_latency: got %0d, expected %0d", d0_cyc - start_cyc, BTO);
    end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL to_starts: got %0d, expected 1", start_cnt - s0); end
    req(1, 1'b1, 8'h05, 8'h00);
    wait_done(1, r1_done_n + 1, 300);
    checks++;
    if ({d1_err, d1_rdata} !== {1'b0, 8'h37}) begin
      errors++; $display("FAIL to_next_req: got err=%b rdata=%h, expected 0/37", d1_err, d1_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] obs;
    int n = 0;
    int rc = rise_cyc;
    int d0 = r0_done_n;
    req(0, 1'b0, 8'h50, 8'h99);
    r1_rw = 1'b1; r1_addr = 8'h05; r1_wdata = 8'h00; r1_valid = 1'b1;
    while (rise_cyc == rc && n < 100) begin step(); n++; end
    repeat (5) step();
    sys_rst = 1'b1;
    #1;
    obs = {r0_accept, r1_accept, r0_done, r1_done, r0_err, r1_err, iic_start, iic_rw_flag,
           iic_word_addr, iic_wdata};
    checks++;
    if (obs !== 24'h0) begin errors++; $display("FAIL midrst_outputs: got %h, expected 000000", obs); end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h, expected 00", rdata); end
    repeat (3) step();
    sys_rst = 1'b0;
    req(1, 1'b1, 8'h05, 8'h00);
    wait_done(1, r1_done_n + 1, 300);
    checks++;
    if (r0_done_n != d0) begin errors++; $display("FAIL midrst_no_done: got %0d r0 dones, expected 0", r0_done_n - d0); end
    checks++;
    if (d1_rdata !== 8'h37) begin errors++; $display("FAIL midrst_r1_read: got %h, expected 37", d1_rdata); end
  endtask

  initial begin
    sys_rst = 1'b1;
    r0_valid = 1'b0; r0_rw = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
    r1_valid = 1'b0; r1_rw = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_retry();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
